// File: rtl/movimentador_tiros.sv
// Shot mover: on request, walks every shot RAM slot, advances active shots one cell and retires
// those leaving the field. Define TIRO_WRAP_EN to wrap coordinates around the field instead.
module movimentador_tiros #(
   parameter int unsigned N_TIROS    = 8,
   parameter int unsigned COORD_BITS = 4,
   localparam int unsigned A = (N_TIROS > 1) ? $clog2(N_TIROS) : 1,
   localparam int unsigned W = 3 + 2 * COORD_BITS
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         movimenta_tiro,
   output logic         fim_move_tiros,
   output logic [A-1:0] endereco_tiro,
   input  logic [W-1:0] dado_tiro_in,
   output logic [W-1:0] dado_tiro_out,
   output logic         escreve_tiro,
   output logic [A:0]   contagem_ativos,
   output logic [2:0]   db_estado_movimentador_tiros
);

   typedef enum logic [2:0] {
      StInicial  = 3'd0,
      StLe       = 3'd1,
      StAtualiza = 3'd2,
      StProximo  = 3'd3,
      StFim      = 3'd4
   } estado_e;

   localparam logic [A-1:0]          UltimoEnd = A'(N_TIROS - 1);
   localparam logic [COORD_BITS-1:0] Um        = COORD_BITS'(1);
   localparam logic [COORD_BITS-1:0] CoordMax  = '1;
   localparam logic [A:0]            UmCont    = (A + 1)'(1);

   estado_e       estado_q, estado_d;
   logic [A-1:0]  endereco_q, endereco_d;
   logic [A:0]    acumulador_q, acumulador_d;
   logic [A:0]    contagem_q, contagem_d;

   logic                  ativo, saiu;
   logic [1:0]            dir;
   logic [COORD_BITS-1:0] x, y, x_mov, y_mov;
   logic [W-1:0]          palavra_movida;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q     <= StInicial;
         endereco_q   <= '0;
         acumulador_q <= '0;
         contagem_q   <= '0;
      end else begin
         estado_q     <= estado_d;
         endereco_q   <= endereco_d;
         acumulador_q <= acumulador_d;
         contagem_q   <= contagem_d;
      end
   end

   // Moved word for the slot currently on dado_tiro_in.
   always_comb begin
      ativo = dado_tiro_in[W-1];
      dir   = dado_tiro_in[W-2:W-3];
      x     = dado_tiro_in[2*COORD_BITS-1 -: COORD_BITS];
      y     = dado_tiro_in[COORD_BITS-1:0];
      x_mov = x;
      y_mov = y;
      saiu  = 1'b0;
      case (dir)
         2'b00: begin
            saiu  = (y == '0);
            y_mov = y - Um;
         end
         2'b01: begin
            saiu  = (x == CoordMax);
            x_mov = x + Um;
         end
         2'b10: begin
            saiu  = (y == CoordMax);
            y_mov = y + Um;
         end
         default: begin
            saiu  = (x == '0);
            x_mov = x - Um;
         end
      endcase
`ifdef TIRO_WRAP_EN
      saiu = 1'b0;
`endif
      palavra_movida = saiu ? {1'b0, dir, x, y} : {1'b1, dir, x_mov, y_mov};
   end

   always_comb begin
      estado_d     = estado_q;
      endereco_d   = endereco_q;
      acumulador_d = acumulador_q;
      contagem_d   = contagem_q;
      unique case (estado_q)
         StInicial: begin
            endereco_d   = '0;
            acumulador_d = '0;
            if (movimenta_tiro) estado_d = StLe;
         end
         StLe: estado_d = StAtualiza;
         StAtualiza: begin
            if (ativo && !saiu) acumulador_d = acumulador_q + UmCont;
            estado_d = StProximo;
         end
         StProximo: begin
            if (endereco_q == UltimoEnd) begin
               contagem_d = acumulador_q;
               estado_d   = StFim;
            end else begin
               endereco_d = endereco_q + A'(1);
               estado_d   = StLe;
            end
         end
         StFim: begin
            if (!movimenta_tiro) begin
               estado_d     = StInicial;
               endereco_d   = '0;
               acumulador_d = '0;
            end
         end
         default: estado_d = StInicial;
      endcase
   end

   // Reset gates the write so a pending slot update never lands during reset.
   always_comb begin
      escreve_tiro                 = (estado_q == StAtualiza) && ativo && !reset;
      dado_tiro_out                = (estado_q == StAtualiza) ? palavra_movida : '0;
      fim_move_tiros               = (estado_q == StFim);
      endereco_tiro                = endereco_q;
      contagem_ativos              = contagem_q;
      db_estado_movimentador_tiros = estado_q;
   end

endmodule
